// File: rtl/sub_64_iter.sv
// Iterative subtractor: a - b computed as a + ~b + 1, one CHUNK-wide slice
// per cycle, LSB slice first, carry held in a register between slices.
// Reports unsigned borrow or signed overflow depending on the latched sign.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready=1
// CALC  | slice k of the difference is formed each cycle, k = 0..NCHUNK-1
// DONE  | d/overflow valid; held until out_ready
module sub_64_iter #(
   parameter int WIDTH  = 64,
   parameter int CHUNK  = 16,
   parameter int NCHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             overflow
);

   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             sign_r;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] acc;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] acc_next;
   logic             ovf_next;

   // Current slice of a + ~b + carry and the accumulator with it merged in.
   always_comb begin
      a_chunk   = a_r[k*CHUNK +: CHUNK];
      b_chunk   = b_r[k*CHUNK +: CHUNK];
      chunk_sum = {1'b0, a_chunk} + {1'b0, ~b_chunk} + (CHUNK+1)'(carry);
      acc_next  = acc;
      acc_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      // A missing final carry-out means the unsigned subtraction borrowed.
      if (sign_r)
         ovf_next = (a_r[WIDTH-1] != b_r[WIDTH-1]) & (acc_next[WIDTH-1] != a_r[WIDTH-1]);
      else
         ovf_next = ~chunk_sum[CHUNK];
   end

   // Handshake FSM, slice iteration and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         d         <= '0;
         overflow  <= 1'b0;
         k         <= '0;
         carry     <= 1'b0;
         acc       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         sign_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= b;
                  sign_r   <= sign;
                  k        <= '0;
                  carry    <= 1'b1;
                  acc      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               carry <= chunk_sum[CHUNK];
               k     <= k + 1'b1;
               if (k == KLAST) begin
                  k         <= '0;
                  d         <= acc_next;
                  overflow  <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_64_iter.sv
// Bench for sub_64_iter: directed vector table, backpressure and reset
// sequences, then randomized operations against a plain-arithmetic model.
module tb_sub_64_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        sign;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] d;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   sub_64_iter #(.WIDTH(64), .CHUNK(16), .NCHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sign      (sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        s;
      logic [63:0] d;
      logic        ov;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h want 0x%016h", name, act, exp);
      end
   endtask

   // Reference: true mathematical difference and range tests on it.
   function automatic void model(input logic [63:0] xa, input logic [63:0] xb, input logic s,
                                 output logic [63:0] md, output logic mov);
      logic signed [64:0] full;
      logic signed [64:0] maxv;
      logic signed [64:0] minv;
      md   = xa - xb;
      maxv = 65'sh0_7FFF_FFFF_FFFF_FFFF;
      minv = -65'sh0_8000_0000_0000_0000;
      full = $signed({xa[63], xa}) - $signed({xb[63], xb});
      if (!s) mov = (xa < xb);
      else    mov = (full > maxv) || (full < minv);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [63:0] xa, input logic [63:0] xb, input logic s,
                         input logic [63:0] ed, input logic eo, input int stall, input string name);
      int lat;
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check({name, " ready_wait"}, 64'(in_ready), 64'd1);
      a         = xa;
      b         = xb;
      sign      = s;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      tick();
      in_valid = 1'b0;
      check({name, " busy_after_accept"}, 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
      end
      check({name, " latency"}, 64'(lat), 64'd4);
      check({name, " d"}, d, ed);
      check({name, " ovf"}, 64'(overflow), 64'(eo));
      for (int i = 0; i < stall; i++) begin
         tick();
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         sign = ~sign;
         check({name, " hold_valid"}, 64'(out_valid), 64'd1);
         check({name, " hold_ready"}, 64'(in_ready), 64'd0);
         check({name, " hold_d"}, d, ed);
         check({name, " hold_ovf"}, 64'(overflow), 64'(eo));
      end
      out_ready = 1'b1;
      tick();
      check({name, " drain_valid"}, 64'(out_valid), 64'd0);
      check({name, " drain_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] md;
      logic        mov;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      logic [63:0] corner[5];

      vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, "u_5m3"};
      vecs[1] = '{64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "u_3m5"};
      vecs[2] = '{64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "s_3m5"};
      vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "s_min_m1"};
      vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b1, "s_max_mneg1"};
      vecs[5] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, "ripple"};
      vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, "u_b0"};
      vecs[7] = '{64'h8765_4321_0FED_CBA9, 64'd0, 1'b1, 64'h8765_4321_0FED_CBA9, 1'b0, "s_b0"};
      vecs[8] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0, 1'b0, "u_eq"};
      vecs[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 1'b0, "s_eq"};

      corner[0] = 64'd0;
      corner[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      corner[2] = 64'h8000_0000_0000_0000;
      corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
      corner[4] = 64'h0000_0000_0001_0000;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sign = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst d", d, 64'd0);
      check("rst ovf", 64'(overflow), 64'd0);

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].d, vecs[i].ov, 0, vecs[i].name);

      // Backpressure: ten stalled cycles with operand inputs churning.
      run_op(64'h0000_0000_0000_0064, 64'h0000_0000_0000_0001, 1'b0, 64'd99, 1'b0, 10, "backpressure");

      // Reset during the second CALC cycle aborts the operation.
      a = 64'd100; b = 64'd1; sign = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort out_valid", 64'(out_valid), 64'd0);
      check("abort d", d, 64'd0);
      check("abort in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort no_result", 64'(out_valid), 64'd0);
      end

      // in_valid during reset is not an acceptance.
      rst = 1'b1; in_valid = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("rst_accept in_ready", 64'(in_ready), 64'd1);
      check("rst_accept out_valid", 64'(out_valid), 64'd0);

      run_op(64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 0, "after_reset");

      for (int n = 0; n < 150; n++) begin
         ra = (n % 4 == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
         rb = (n % 5 == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
         if (n % 7 == 0) rb = ra;
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, md, mov);
         run_op(ra, rb, rs, md, mov, $urandom_range(0, 3), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
